core_wb_arbiter: RTL and testbench
==================================

# core_wb_arbiter

Writeback-port arbiter between the execution units and the register file. Five result producers (ALU A, ALU B, multiplier, load/store, branch-link) compete for the two register-file write ports. The block grants up to two results per cycle and registers them onto the write ports. It also exports a pending-write mask for hazard checking, and raises an ALU hold toward dispatch when a slow unit is starving.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied cycles after which a slow unit (mul/ldst/branch) is promoted above ALU B.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  5  per-requester valid; index 0 = alu_a, 1 = alu_b, 2 = mul, 3 = ldst, 4 = branch.
- `req_rd`  in  5×`reg_num`  destination register per requester.
- `req_value`  in  5×`word`  result per requester.
- `req_ready`  out  5  combinational grant; a transfer occurs when valid && ready.
- `wr_en_a`, `wr_en_b`  out  1  registered write enables for ports A and B.
- `wr_r_a`, `wr_r_b`  out  `reg_num`  registered write register.
- `wr_value_a`, `wr_value_b`  out  `word`  registered write data.
- `pending_mask`  out  `hword`  bit r set iff some requester has req_valid with req_rd == r this cycle and is not granted; combinational.
- `alu_hold`  out  1  registered; asks dispatch not to start ALU ops next cycle.
- `flush`  in  1  drops branch-unit starvation state only; in-flight requests still complete.

## Operation
- Requesters hold valid, rd and value stable until granted. Dropping valid without a grant is illegal; the bench asserts this.
- Candidate order each cycle:
  - alu_a first.
  - The starving slow unit, if any. Starving means `wait_cnt[i] >= STARVE_LIMIT`. If several are starving, the round-robin pointer picks among them.
  - alu_b.
  - The remaining slow units in round-robin order, starting at `rr_ptr` (mul → ldst → branch → mul).
- The first two valid candidates are granted, subject to the same-rd rule below.
- Same-rd rule: a candidate whose `req_rd` equals the rd of an already-selected grant this cycle is skipped and retries next cycle. Skipping does not consume a port, so the next candidate is eligible.
- Port assignment: the first grant goes to port A, the second to port B.
- `rr_ptr` advances to the unit after the last slow unit granted in a cycle. It holds if no slow unit is granted.
- `wait_cnt[i]` (mul/ldst/branch, 3 bits, saturating at 7):
  - Increments on each cycle with valid && !ready.
  - Clears on grant or when valid is low.
  - `flush` clears `wait_cnt[4]`.
- `alu_hold` is registered, set to (any `wait_cnt` ≥ `STARVE_LIMIT` after update). Dispatch treats it like `wb_stall_branch`.

## Timing
- Grant to write: a transfer in cycle N appears on `wr_*` in cycle N+1, for exactly one cycle.
- `req_ready` depends combinationally on all `req_valid` and `req_rd` inputs, and on registered state only. It has no dependency on `wr_*`.
- Reset values:
  - `wr_en_a`/`wr_en_b` = 0.
  - `wr_r_*` = 0.
  - `wr_value_*` = 0.
  - `alu_hold` = 0.
  - `rr_ptr` = mul.
  - All `wait_cnt` = 0.
- During reset, `req_ready` = 0 and `pending_mask` reflects valid inputs.
- Reset asserted mid-request: the request is not granted that cycle and is retried after reset deasserts.
- One valid requester: granted on port A; port B is idle (`wr_en_b` = 0).
- Five valid requesters: exactly two are granted. `pending_mask` marks the other three rds, with duplicate rds ORed into a single bit.
- All candidates target the same rd: only one is granted, and the port-B write is idle that cycle.

## Structure
- Add to the shared uarch package:
  - `wb_req_id` enum (ALU_A, ALU_B, MUL, LDST, BRANCH).
  - `WB_REQUESTERS` = 5.
  - `wb_port` struct {en, r, value}.
- Sub-module `core_wb_pick`: combinational selector for the first two eligible candidates from an ordered candidate list with the same-rd skip. It is instantiated once.
- Estimated size: ~200 RTL lines.

## Test plan
- ALU A writes r3 = 0x11, ALU B writes r4 = 0x22 in the same cycle → next cycle port A = (r3, 0x11), port B = (r4, 0x22); `req_ready` = 00011.
- All five valid with distinct rds, `rr_ptr` = mul → grants alu_a and alu_b only; `pending_mask` has mul/ldst/branch rds set; `wait_cnt` of each = 1.
- ALU A and ALU B valid every cycle, ldst waiting, `STARVE_LIMIT` = 4 → after 4 denials ldst is granted on port B in cycle 5, alu_b is denied that cycle, and `alu_hold` rises the cycle after the count reaches 4.
- mul and ldst both target r7, ALUs idle → one of them is granted (per `rr_ptr`), the other is granted the next cycle; no cycle writes r7 on both ports.
- Only ldst, branch and mul valid, repeated over 6 cycles with grants → each pair rotates through the round-robin and no unit waits more than 1 cycle.
- `rst` asserted for one cycle while mul is valid → `wr_en_*` = 0 and `ready` = 0 during reset; mul is granted the cycle after `rst` falls, with `wait_cnt` cleared.

Source files
------------

// File: rtl/core_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: requester ids, port record, vector types.
package core_wb_arbiter_pkg;

    localparam int REG_W         = 4;
    localparam int WORD_W        = 32;
    localparam int HWORD_W       = 16;
    localparam int WB_REQUESTERS = 5;

    typedef logic [REG_W-1:0]   reg_num_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [HWORD_W-1:0] hword_t;

    typedef enum logic [2:0] {
        ALU_A  = 3'd0,
        ALU_B  = 3'd1,
        MUL    = 3'd2,
        LDST   = 3'd3,
        BRANCH = 3'd4
    } wb_req_id;

    typedef struct packed {
        logic     en;
        reg_num_t r;
        word_t    value;
    } wb_port;

    typedef logic [WB_REQUESTERS-1:0][REG_W-1:0]  rd_vec_t;
    typedef logic [WB_REQUESTERS-1:0][WORD_W-1:0] value_vec_t;
    typedef logic [WB_REQUESTERS-1:0][2:0]        id_vec_t;

    // Round-robin successor among the slow units: mul -> ldst -> branch -> mul.
    function automatic logic [2:0] slow_after(input logic [2:0] u);
        logic [2:0] n;
        case (u)
            MUL:     n = LDST;
            LDST:    n = BRANCH;
            default: n = MUL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/core_wb_arbiter_if.sv
// Requester handshake and register-file write-port bundle for the writeback arbiter.
interface core_wb_arbiter_if;
    import core_wb_arbiter_pkg::*;

    logic [WB_REQUESTERS-1:0] req_valid;
    rd_vec_t                  req_rd;
    value_vec_t               req_value;
    logic [WB_REQUESTERS-1:0] req_ready;
    logic                     flush;

    logic     wr_en_a;
    logic     wr_en_b;
    reg_num_t wr_r_a;
    reg_num_t wr_r_b;
    word_t    wr_value_a;
    word_t    wr_value_b;
    hword_t   pending_mask;
    logic     alu_hold;

    modport master (
        output req_valid, req_rd, req_value, flush,
        input  req_ready, wr_en_a, wr_en_b, wr_r_a, wr_r_b,
               wr_value_a, wr_value_b, pending_mask, alu_hold
    );

    modport slave (
        input  req_valid, req_rd, req_value, flush,
        output req_ready, wr_en_a, wr_en_b, wr_r_a, wr_r_b,
               wr_value_a, wr_value_b, pending_mask, alu_hold
    );

endinterface

// File: rtl/core_wb_pick.sv
// Picks the first two valid candidates of an ordered list, skipping a second with the first's rd.
// Latency: purely combinational.
// Backpressure: unpicked candidates simply see no grant and retry.
module core_wb_pick
    import core_wb_arbiter_pkg::*;
(
    input  id_vec_t                  cand,
    input  logic [WB_REQUESTERS-1:0] valid,
    input  rd_vec_t                  rd,
    output logic [WB_REQUESTERS-1:0] grant,
    output logic                     sel_a_vld,
    output logic [2:0]               sel_a_id,
    output logic                     sel_b_vld,
    output logic [2:0]               sel_b_id
);

    logic [2:0] id;

    always_comb begin
        grant     = '0;
        sel_a_vld = 1'b0;
        sel_a_id  = '0;
        sel_b_vld = 1'b0;
        sel_b_id  = '0;
        id        = '0;
        for (int k = 0; k < WB_REQUESTERS; k++) begin
            id = cand[k];
            if (valid[id]) begin
                if (!sel_a_vld) begin
                    sel_a_vld = 1'b1;
                    sel_a_id  = id;
                    grant[id] = 1'b1;
                end else if (!sel_b_vld && (rd[id] != rd[sel_a_id])) begin
                    // A same-rd candidate is skipped without using up port B.
                    sel_b_vld = 1'b1;
                    sel_b_id  = id;
                    grant[id] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_wb_arbiter.sv
// Arbitrates five result producers onto two register-file write ports.
// Latency: grant is combinational, the write appears on wr_* one cycle later.
// Backpressure: ungranted requesters hold valid; starving slow units outrank alu_b and raise alu_hold.
module core_wb_arbiter
    import core_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    core_wb_arbiter_if.slave  bus
);

    logic [2:0] rr_ptr;
    logic [2:0] rr_next;
    logic [2:0] wait_cnt [2:4];
    logic [2:0] wait_nxt [2:4];
    logic       alu_hold_q;
    wb_port     port_a;
    wb_port     port_b;

    logic [WB_REQUESTERS-1:0] starving;
    logic [2:0]               seq [3];
    logic                     starve_found;
    logic [1:0]               starve_k;
    id_vec_t                  cand;

    logic [WB_REQUESTERS-1:0] grant;
    logic                     sel_a_vld;
    logic [2:0]               sel_a_id;
    logic                     sel_b_vld;
    logic [2:0]               sel_b_id;
    logic                     any_starve_nxt;

    always_comb begin
        starving = '0;
        for (int i = 2; i <= 4; i++) begin
            starving[i] = int'(wait_cnt[i]) >= STARVE_LIMIT;
        end
    end

    // Candidate order: alu_a, starving slow unit (rr tie-break), alu_b, remaining slow units in rr order.
    always_comb begin
        seq[0]       = rr_ptr;
        seq[1]       = slow_after(rr_ptr);
        seq[2]       = slow_after(seq[1]);
        starve_found = 1'b0;
        starve_k     = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!starve_found && starving[seq[k]]) begin
                starve_found = 1'b1;
                starve_k     = 2'(k);
            end
        end

        cand[0] = ALU_A;
        if (starve_found) begin
            cand[1] = seq[starve_k];
            cand[2] = ALU_B;
            case (starve_k)
                2'd0: begin
                    cand[3] = seq[1];
                    cand[4] = seq[2];
                end
                2'd1: begin
                    cand[3] = seq[0];
                    cand[4] = seq[2];
                end
                default: begin
                    cand[3] = seq[0];
                    cand[4] = seq[1];
                end
            endcase
        end else begin
            cand[1] = ALU_B;
            cand[2] = seq[0];
            cand[3] = seq[1];
            cand[4] = seq[2];
        end
    end

    core_wb_pick u_pick (
        .cand      (cand),
        .valid     (bus.req_valid),
        .rd        (bus.req_rd),
        .grant     (grant),
        .sel_a_vld (sel_a_vld),
        .sel_a_id  (sel_a_id),
        .sel_b_vld (sel_b_vld),
        .sel_b_id  (sel_b_id)
    );

    assign bus.req_ready = rst ? '0 : grant;

    always_comb begin
        bus.pending_mask = '0;
        for (int i = 0; i < WB_REQUESTERS; i++) begin
            if (bus.req_valid[i] && !bus.req_ready[i]) begin
                bus.pending_mask[bus.req_rd[i]] = 1'b1;
            end
        end
    end

    // Port B is later in candidate order, so a slow grant there decides the pointer.
    always_comb begin
        rr_next = rr_ptr;
        if (sel_a_vld && (sel_a_id >= 3'(MUL))) begin
            rr_next = slow_after(sel_a_id);
        end
        if (sel_b_vld && (sel_b_id >= 3'(MUL))) begin
            rr_next = slow_after(sel_b_id);
        end
    end

    always_comb begin
        any_starve_nxt = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            if (!bus.req_valid[i] || grant[i]) begin
                wait_nxt[i] = '0;
            end else if (wait_cnt[i] != 3'd7) begin
                wait_nxt[i] = wait_cnt[i] + 3'd1;
            end else begin
                wait_nxt[i] = wait_cnt[i];
            end
        end
        if (bus.flush) begin
            wait_nxt[4] = '0;
        end
        for (int i = 2; i <= 4; i++) begin
            if (int'(wait_nxt[i]) >= STARVE_LIMIT) begin
                any_starve_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_a     <= '0;
            port_b     <= '0;
            rr_ptr     <= MUL;
            alu_hold_q <= 1'b0;
            for (int i = 2; i <= 4; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            port_a     <= sel_a_vld ? '{en: 1'b1, r: bus.req_rd[sel_a_id], value: bus.req_value[sel_a_id]} : '0;
            port_b     <= sel_b_vld ? '{en: 1'b1, r: bus.req_rd[sel_b_id], value: bus.req_value[sel_b_id]} : '0;
            rr_ptr     <= rr_next;
            alu_hold_q <= any_starve_nxt;
            for (int i = 2; i <= 4; i++) begin
                wait_cnt[i] <= wait_nxt[i];
            end
        end
    end

    assign bus.wr_en_a    = port_a.en;
    assign bus.wr_r_a     = port_a.r;
    assign bus.wr_value_a = port_a.value;
    assign bus.wr_en_b    = port_b.en;
    assign bus.wr_r_b     = port_b.r;
    assign bus.wr_value_b = port_b.value;
    assign bus.alu_hold   = alu_hold_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: grant order, ports, pending mask, starvation, reset, flush.
module tb_core_wb_arbiter;
    import core_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    core_wb_arbiter_if wb ();

    core_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (wb.slave)
    );

    always #5 clk = ~clk;

    // Requesters may not drop valid before being granted.
    logic [4:0] pend_q = '0;
    always @(posedge clk) begin
        if (!rst && ((pend_q & ~wb.req_valid) != 5'b0)) begin
            errors++;
            $display("FAIL valid_drop: pending %b valid %b", pend_q, wb.req_valid);
        end
        pend_q <= rst ? 5'b0 : (wb.req_valid & ~wb.req_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] rd, input logic [31:0] val);
        wb.req_valid[id] = 1'b1;
        wb.req_rd[id]    = rd;
        wb.req_value[id] = val;
    endtask

    task automatic do_reset();
        wb.req_valid = '0;
        wb.flush     = 1'b0;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
    endtask

    task automatic test_reset();
        wb.req_valid = '0;
        wb.req_rd    = '0;
        wb.req_value = '0;
        wb.flush     = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        set_req(0, 4'd2, 32'hAA);
        #1;
        checks++; if (wb.req_ready !== 5'b0) begin errors++; $display("FAIL reset_ready: got %b want 00000", wb.req_ready); end
        checks++; if (wb.pending_mask !== 16'h0004) begin errors++; $display("FAIL reset_mask: got %h want 0004", wb.pending_mask); end
        checks++; if ({wb.wr_en_a, wb.wr_en_b, wb.alu_hold} !== 3'b0) begin errors++; $display("FAIL reset_en_hold: got %b want 000", {wb.wr_en_a, wb.wr_en_b, wb.alu_hold}); end
        checks++; if ({wb.wr_r_a, wb.wr_r_b, wb.wr_value_a, wb.wr_value_b} !== 72'b0) begin errors++; $display("FAIL reset_data: got nonzero write data"); end
        checks++; if (dut.rr_ptr !== 3'd2) begin errors++; $display("FAIL reset_rr: got %0d want 2", dut.rr_ptr); end
        wb.req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_two_alus();
        do_reset();
        set_req(0, 4'd3, 32'h11);
        set_req(1, 4'd4, 32'h22);
        #1;
        checks++; if (wb.req_ready !== 5'b00011) begin errors++; $display("FAIL two_alu_ready: got %b want 00011", wb.req_ready); end
        checks++; if (wb.pending_mask !== 16'h0) begin errors++; $display("FAIL two_alu_mask: got %h want 0000", wb.pending_mask); end
        tick();
        wb.req_valid = '0;
        checks++; if ({wb.wr_en_a, wb.wr_r_a, wb.wr_value_a} !== {1'b1, 4'd3, 32'h11}) begin errors++; $display("FAIL two_alu_port_a: got %b/%0d/%h want 1/3/11", wb.wr_en_a, wb.wr_r_a, wb.wr_value_a); end
        checks++; if ({wb.wr_en_b, wb.wr_r_b, wb.wr_value_b} !== {1'b1, 4'd4, 32'h22}) begin errors++; $display("FAIL two_alu_port_b: got %b/%0d/%h want 1/4/22", wb.wr_en_b, wb.wr_r_b, wb.wr_value_b); end
        tick();
        checks++; if ({wb.wr_en_a, wb.wr_en_b} !== 2'b00) begin errors++; $display("FAIL two_alu_one_cycle: got %b want 00", {wb.wr_en_a, wb.wr_en_b}); end
    endtask

    task automatic test_all_five();
        do_reset();
        set_req(0, 4'd1, 32'h1);
        set_req(1, 4'd2, 32'h2);
        set_req(2, 4'd5, 32'h5);
        set_req(3, 4'd6, 32'h6);
        set_req(4, 4'd9, 32'h9);
        #1;
        checks++; if (wb.req_ready !== 5'b00011) begin errors++; $display("FAIL five_ready: got %b want 00011", wb.req_ready); end
        checks++; if (wb.pending_mask !== 16'h0260) begin errors++; $display("FAIL five_mask: got %h want 0260", wb.pending_mask); end
        tick();
        wb.req_valid[1:0] = 2'b00;
        checks++; if ({dut.wait_cnt[2], dut.wait_cnt[3], dut.wait_cnt[4]} !== 9'b001_001_001) begin errors++; $display("FAIL five_wait: got %0d %0d %0d want 1 1 1", dut.wait_cnt[2], dut.wait_cnt[3], dut.wait_cnt[4]); end
    endtask

    task automatic test_dup_rds();
        do_reset();
        set_req(0, 4'd1, 32'h1);
        set_req(1, 4'd2, 32'h2);
        set_req(2, 4'd8, 32'h8);
        set_req(3, 4'd8, 32'h18);
        set_req(4, 4'd10, 32'hA);
        #1;
        checks++; if (wb.req_ready !== 5'b00011) begin errors++; $display("FAIL dup_ready: got %b want 00011", wb.req_ready); end
        checks++; if (wb.pending_mask !== 16'h0500) begin errors++; $display("FAIL dup_mask: got %h want 0500", wb.pending_mask); end
    endtask

    task automatic test_same_rd_all();
        do_reset();
        for (int i = 0; i < 5; i++) set_req(i, 4'd7, 32'h70 + i);
        #1;
        checks++; if (wb.req_ready !== 5'b00001) begin errors++; $display("FAIL samerd_ready: got %b want 00001", wb.req_ready); end
        checks++; if (wb.pending_mask !== 16'h0080) begin errors++; $display("FAIL samerd_mask: got %h want 0080", wb.pending_mask); end
        tick();
        wb.req_valid[0] = 1'b0;
        checks++; if ({wb.wr_en_a, wb.wr_r_a, wb.wr_value_a, wb.wr_en_b} !== {1'b1, 4'd7, 32'h70, 1'b0}) begin errors++; $display("FAIL samerd_ports: got %b/%0d/%h b_en %b want 1/7/70 b_en 0", wb.wr_en_a, wb.wr_r_a, wb.wr_value_a, wb.wr_en_b); end
    endtask

    task automatic test_starvation();
        do_reset();
        set_req(3, 4'd6, 32'h66);
        for (int c = 1; c <= 4; c++) begin
            set_req(0, 4'd1, 32'h10 + c);
            set_req(1, 4'd2, 32'h20 + c);
            #1;
            checks++; if (wb.req_ready !== 5'b00011) begin errors++; $display("FAIL starve_ready_c%0d: got %b want 00011", c, wb.req_ready); end
            tick();
            checks++; if (wb.alu_hold !== (c == 4)) begin errors++; $display("FAIL starve_hold_c%0d: got %b want %b", c, wb.alu_hold, (c == 4)); end
        end
        set_req(0, 4'd1, 32'h15);
        set_req(1, 4'd2, 32'h25);
        #1;
        checks++; if (wb.req_ready !== 5'b01001) begin errors++; $display("FAIL starve_ready_c5: got %b want 01001", wb.req_ready); end
        tick();
        checks++; if ({wb.wr_en_b, wb.wr_r_b, wb.wr_value_b} !== {1'b1, 4'd6, 32'h66}) begin errors++; $display("FAIL starve_port_b: got %b/%0d/%h want 1/6/66", wb.wr_en_b, wb.wr_r_b, wb.wr_value_b); end
        checks++; if (wb.alu_hold !== 1'b0) begin errors++; $display("FAIL starve_hold_clear: got %b want 0", wb.alu_hold); end
        wb.req_valid[3] = 1'b0;
        set_req(0, 4'd1, 32'h16);
        #1;
        checks++; if (wb.req_ready !== 5'b00011) begin errors++; $display("FAIL starve_ready_c6: got %b want 00011", wb.req_ready); end
        tick();
        wb.req_valid = '0;
        checks++; if (wb.wr_value_b !== 32'h25) begin errors++; $display("FAIL starve_alub_late: got %h want 25", wb.wr_value_b); end
    endtask

    task automatic test_same_rd_slow();
        do_reset();
        set_req(2, 4'd7, 32'h70);
        set_req(3, 4'd7, 32'h71);
        #1;
        checks++; if (wb.req_ready !== 5'b00100) begin errors++; $display("FAIL slow_rd_ready1: got %b want 00100", wb.req_ready); end
        tick();
        wb.req_valid[2] = 1'b0;
        checks++; if ({wb.wr_en_a, wb.wr_value_a, wb.wr_en_b} !== {1'b1, 32'h70, 1'b0}) begin errors++; $display("FAIL slow_rd_write1: got %b/%h b_en %b want 1/70 b_en 0", wb.wr_en_a, wb.wr_value_a, wb.wr_en_b); end
        #1;
        checks++; if (wb.req_ready !== 5'b01000) begin errors++; $display("FAIL slow_rd_ready2: got %b want 01000", wb.req_ready); end
        tick();
        wb.req_valid = '0;
        checks++; if ({wb.wr_en_a, wb.wr_r_a, wb.wr_value_a, wb.wr_en_b} !== {1'b1, 4'd7, 32'h71, 1'b0}) begin errors++; $display("FAIL slow_rd_write2: got %b/%0d/%h b_en %b want 1/7/71 b_en 0", wb.wr_en_a, wb.wr_r_a, wb.wr_value_a, wb.wr_en_b); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_rdy [3];
        logic [3:0] exp_ra  [3];
        logic [3:0] exp_rb  [3];
        exp_rdy[0] = 5'b01100; exp_ra[0] = 4'd5; exp_rb[0] = 4'd6;
        exp_rdy[1] = 5'b10100; exp_ra[1] = 4'd9; exp_rb[1] = 4'd5;
        exp_rdy[2] = 5'b11000; exp_ra[2] = 4'd6; exp_rb[2] = 4'd9;
        do_reset();
        set_req(2, 4'd5, 32'h5);
        set_req(3, 4'd6, 32'h6);
        set_req(4, 4'd9, 32'h9);
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (wb.req_ready !== exp_rdy[c % 3]) begin errors++; $display("FAIL rr_ready_c%0d: got %b want %b", c, wb.req_ready, exp_rdy[c % 3]); end
            tick();
            checks++; if ({wb.wr_r_a, wb.wr_r_b} !== {exp_ra[c % 3], exp_rb[c % 3]}) begin errors++; $display("FAIL rr_ports_c%0d: got %0d/%0d want %0d/%0d", c, wb.wr_r_a, wb.wr_r_b, exp_ra[c % 3], exp_rb[c % 3]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 4'd1, 32'h1);
        tick();
        wb.req_valid = '0;
        set_req(2, 4'd3, 32'h33);
        rst = 1'b1;
        #1;
        checks++; if (wb.req_ready !== 5'b0) begin errors++; $display("FAIL midrst_ready: got %b want 00000", wb.req_ready); end
        checks++; if (wb.pending_mask !== 16'h0008) begin errors++; $display("FAIL midrst_mask: got %h want 0008", wb.pending_mask); end
        tick();
        checks++; if ({wb.wr_en_a, wb.wr_en_b} !== 2'b00) begin errors++; $display("FAIL midrst_wr_en: got %b want 00", {wb.wr_en_a, wb.wr_en_b}); end
        rst = 1'b0;
        #1;
        checks++; if (wb.req_ready !== 5'b00100) begin errors++; $display("FAIL midrst_retry: got %b want 00100", wb.req_ready); end
        checks++; if (dut.wait_cnt[2] !== 3'd0) begin errors++; $display("FAIL midrst_wait: got %0d want 0", dut.wait_cnt[2]); end
        tick();
        wb.req_valid = '0;
        checks++; if ({wb.wr_en_a, wb.wr_r_a, wb.wr_value_a} !== {1'b1, 4'd3, 32'h33}) begin errors++; $display("FAIL midrst_write: got %b/%0d/%h want 1/3/33", wb.wr_en_a, wb.wr_r_a, wb.wr_value_a); end
    endtask

    task automatic test_flush();
        do_reset();
        set_req(4, 4'd9, 32'h9);
        for (int c = 1; c <= 5; c++) begin
            set_req(0, 4'd1, 32'h10 + c);
            set_req(1, 4'd2, 32'h20 + c);
            wb.flush = (c == 4);
            tick();
            if (c == 3) begin
                checks++; if (dut.wait_cnt[4] !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d want 3", dut.wait_cnt[4]); end
            end else if (c == 4) begin
                checks++; if ({dut.wait_cnt[4], wb.alu_hold} !== {3'd0, 1'b0}) begin errors++; $display("FAIL flush_clear: got %0d hold %b want 0 hold 0", dut.wait_cnt[4], wb.alu_hold); end
            end else if (c == 5) begin
                checks++; if (dut.wait_cnt[4] !== 3'd1) begin errors++; $display("FAIL flush_after: got %0d want 1", dut.wait_cnt[4]); end
            end
        end
        wb.flush = 1'b0;
    endtask

    initial begin
        wb.req_valid = '0;
        wb.req_rd    = '0;
        wb.req_value = '0;
        wb.flush     = 1'b0;
        test_reset();
        test_two_alus();
        test_all_five();
        test_dup_rds();
        test_same_rd_all();
        test_starvation();
        test_same_rd_slow();
        test_round_robin();
        test_reset_mid();
        test_flush();
        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
